// File: rtl/net_engine_pkg.sv
// Shared types and default sizes for the net engine AXI4-Stream blocks.
package net_engine_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } tx_state_t;

  localparam int C_DEF_TDATA_WIDTH   = 32;
  localparam int C_DEF_START_COUNT   = 16;
  localparam int C_DEF_FIFO_DEPTH    = 16;
  localparam int C_DEF_PKT_LEN_WIDTH = 16;
  localparam int C_DEF_FIFO_AW       = $clog2(C_DEF_FIFO_DEPTH);

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/net_engine_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Shared by the stream receiver and transmitter.
module net_engine_sync_fifo
  import net_engine_pkg::*;
#(
  parameter int WIDTH = C_DEF_TDATA_WIDTH,
  parameter int DEPTH = C_DEF_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [AW:0]      wr_ptr,
  output logic [AW:0]      rd_ptr
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra MSB tells a full buffer apart from an empty one.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/net_engine_axis_tx.sv
// AXI4-Stream master for the net engine output path: buffers core words and
// frames them into packets of pkt_len beats after a start-up hold-off.
module net_engine_axis_tx
  import net_engine_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = C_DEF_TDATA_WIDTH,
  parameter int C_M00_AXIS_START_COUNT = C_DEF_START_COUNT,
  parameter int C_FIFO_DEPTH           = C_DEF_FIFO_DEPTH,
  parameter int C_PKT_LEN_WIDTH        = C_DEF_PKT_LEN_WIDTH
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic                                core_valid,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   core_data,
  output logic                                core_ready,
  input  logic [C_PKT_LEN_WIDTH-1:0]          pkt_len,
  input  logic                                flush,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic [$clog2(C_FIFO_DEPTH):0]       fifo_level,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         DEBUG_WRITE_POINTER,
  output logic [31:0]                         DEBUG_READ_POINTER,
  output logic [1:0]                          dbg_state
);

  localparam int AW     = $clog2(C_FIFO_DEPTH);
  localparam int STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam logic [31:0] START_LAST =
    (C_M00_AXIS_START_COUNT > 0) ? 32'(C_M00_AXIS_START_COUNT - 1) : 32'd0;
  localparam logic [C_PKT_LEN_WIDTH-1:0] LEN_ONE = 1;

  tx_state_t                  state;
  logic [31:0]                start_cnt;
  logic [C_PKT_LEN_WIDTH-1:0] eff_len;
  logic [C_PKT_LEN_WIDTH-1:0] beat_cnt;
  logic [C_PKT_LEN_WIDTH-1:0] pkt_len_eff;
  logic                       full;
  logic                       empty;
  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;
  logic                       push;
  logic                       pop;
  logic                       last_beat;
  logic                       more_after_pop;

  // Handshakes: a word moves when valid and ready are both high at a rising
  // edge. The core side is gated by buffer space; the stream side holds
  // tvalid/tdata/tlast stable until tready is seen.
  assign core_ready      = m00_axis_aresetn && !full;
  assign push            = core_valid && core_ready;
  assign m00_axis_tvalid = (state == ST_SEND) && !empty;
  assign pop             = m00_axis_tvalid && m00_axis_tready;

  assign last_beat       = (beat_cnt == (eff_len - LEN_ONE));
  assign m00_axis_tlast  = m00_axis_tvalid && last_beat;
  assign m00_axis_tstrb  = {STRB_W{m00_axis_tvalid}};
  assign pkt_len_eff     = (pkt_len == '0) ? LEN_ONE : pkt_len;
  // Buffer still holds a word after this pop: at least two now, or one arriving.
  assign more_after_pop  = (fifo_level[AW:1] != '0) || push;

  assign DEBUG_WRITE_POINTER = 32'(wr_ptr);
  assign DEBUG_READ_POINTER  = 32'(rd_ptr);
  assign dbg_state           = state;

  net_engine_sync_fifo #(
    .WIDTH (C_M00_AXIS_TDATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk    (m00_axis_aclk),
    .rst_n  (m00_axis_aresetn),
    .clear  (flush),
    .push   (push),
    .wdata  (core_data),
    .pop    (pop),
    .rdata  (m00_axis_tdata),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr)
  );

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state     <= ST_INIT;
      start_cnt <= '0;
      eff_len   <= '0;
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else begin
      if (pop && last_beat) pkt_count <= pkt_count + 32'd1;

      case (state)
        ST_INIT: begin
          if (start_cnt >= START_LAST) state <= ST_IDLE;
          else                         start_cnt <= start_cnt + 32'd1;
        end
        ST_IDLE: begin
          if (!empty) begin
            eff_len  <= pkt_len_eff;
            beat_cnt <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop) begin
            if (last_beat) begin
              beat_cnt <= '0;
              // Back-to-back packets: relatch the length without a bubble.
              if (more_after_pop) eff_len <= pkt_len_eff;
              else                state   <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + LEN_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Flush abandons the current packet; the hold-off is never repeated.
      if (flush) begin
        beat_cnt <= '0;
        if (state != ST_INIT) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_net_engine_axis_tx.sv
// Bench for net_engine_axis_tx: table-driven framing cases plus hand-written
// start-up, backpressure, underrun, flush and asynchronous reset sequences.
module tb_net_engine_axis_tx;
  import net_engine_pkg::*;

  localparam int W     = 32;
  localparam int START = 16;
  localparam int DEPTH = 16;
  localparam int PLW   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           core_valid = 1'b0;
  logic [W-1:0]   core_data = '0;
  logic           core_ready;
  logic [PLW-1:0] pkt_len = '0;
  logic           flush = 1'b0;
  logic           tvalid;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tlast;
  logic           tready = 1'b0;
  logic [LW-1:0]  fifo_level;
  logic [31:0]    pkt_count;
  logic [31:0]    dbg_wr;
  logic [31:0]    dbg_rd;
  logic [1:0]     dbg_state;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int           model_beat = 0;
  int           model_len = 1;
  bit           rand_ready = 1'b0;

  typedef struct {
    int len;
    int n;
    bit rnd;
    int pkts;
  } vec_t;
  vec_t vecs[5];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  net_engine_axis_tx #(
    .C_M00_AXIS_TDATA_WIDTH (W),
    .C_M00_AXIS_START_COUNT (START),
    .C_FIFO_DEPTH           (DEPTH),
    .C_PKT_LEN_WIDTH        (PLW)
  ) dut (
    .m00_axis_aclk       (clk),
    .m00_axis_aresetn    (rst_n),
    .core_valid          (core_valid),
    .core_data           (core_data),
    .core_ready          (core_ready),
    .pkt_len             (pkt_len),
    .flush               (flush),
    .m00_axis_tvalid     (tvalid),
    .m00_axis_tdata      (tdata),
    .m00_axis_tstrb      (tstrb),
    .m00_axis_tlast      (tlast),
    .m00_axis_tready     (tready),
    .fifo_level          (fifo_level),
    .pkt_count           (pkt_count),
    .DEBUG_WRITE_POINTER (dbg_wr),
    .DEBUG_READ_POINTER  (dbg_rd),
    .dbg_state           (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: what is seen here is what the next rising
  // edge will transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          if (model_beat == 0) model_len = (pkt_len == '0) ? 1 : int'(pkt_len);
          check("beat_data", tdata, mon_exp);
          check("beat_tlast", tlast, model_beat == model_len - 1);
          check("beat_tstrb", tstrb, {(W/8){1'b1}});
          if (model_beat == model_len - 1) model_beat = 0;
          else                             model_beat++;
        end
      end
      if (core_valid && core_ready && !flush) exp_q.push_back(core_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [W-1:0] d);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    core_valid = 1'b1;
    core_data  = d;
    do begin
      @(negedge clk);
      acc = core_ready;
      tick();
      guard++;
    end while (!acc && guard < 200);
    core_valid = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || tvalid) && guard < 1000) begin
      tick();
      guard++;
    end
    check("drain_complete", exp_q.size() == 0 && !tvalid, 1);
  endtask

  task automatic reset_and_startup();
    rst_n = 1'b0;
    core_valid = 1'b0;
    flush = 1'b0;
    tready = 1'b1;
    pkt_len = 16'd1;
    rand_ready = 1'b0;
    exp_q.delete();
    model_beat = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tstrb", tstrb, 0);
    check("rst_level", fifo_level, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_core_ready", core_ready, 0);
    check("rst_state", dbg_state, ST_INIT);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= START + 1; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        check("ready_after_reset", core_ready, 1);
        core_valid = 1'b1;
        core_data  = 32'h0000_0001;
      end
      if (cyc == 2) core_valid = 1'b0;
      check($sformatf("holdoff_tvalid_c%0d", cyc), tvalid, cyc == START + 1);
    end
    drain();
    check("startup_pkt_count", pkt_count, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;

    vecs[0] = '{len: 4, n: 12, rnd: 1'b0, pkts: 3};
    vecs[1] = '{len: 0, n: 5,  rnd: 1'b0, pkts: 5};
    vecs[2] = '{len: 1, n: 7,  rnd: 1'b1, pkts: 7};
    vecs[3] = '{len: 3, n: 9,  rnd: 1'b1, pkts: 3};
    vecs[4] = '{len: 5, n: 15, rnd: 1'b0, pkts: 3};

    reset_and_startup();

    // Framing table: preloaded rows must stream with no bubbles.
    for (int r = 0; r < 5; r++) begin
      base = int'(pkt_count);
      pkt_len = PLW'(vecs[r].len);
      if (vecs[r].rnd) begin
        rand_ready = 1'b1;
        for (int i = 0; i < vecs[r].n; i++) push_word($urandom());
        drain();
        rand_ready = 1'b0;
        tready = 1'b1;
      end else begin
        tready = 1'b0;
        for (int i = 0; i < vecs[r].n; i++) push_word(W'(r * 256 + i));
        check($sformatf("row%0d_preload_level", r), fifo_level, vecs[r].n);
        tready = 1'b1;
        for (int i = 0; i < vecs[r].n - 1; i++) tick();
        check($sformatf("row%0d_level_before_last", r), fifo_level, 1);
        tick();
        check($sformatf("row%0d_level_after_last", r), fifo_level, 0);
        check($sformatf("row%0d_tvalid_idle", r), tvalid, 0);
      end
      check($sformatf("row%0d_pkt_count", r), pkt_count, base + vecs[r].pkts);
      check($sformatf("row%0d_queue_empty", r), exp_q.size(), 0);
    end

    // Backpressure until full, then drain with pushes still pending.
    base = int'(pkt_count);
    pkt_len = 16'd4;
    tready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(W'(100 + i));
    check("full_core_ready", core_ready, 0);
    check("full_level", fifo_level, 16);
    core_valid = 1'b1;
    core_data  = 32'd116;
    tick();
    check("full_hold_core_ready", core_ready, 0);
    check("full_hold_level", fifo_level, 16);
    tready = 1'b1;
    tick();
    check("ready_after_first_pop", core_ready, 1);
    check("level_after_first_pop", fifo_level, 15);
    for (int i = 16; i < 20; i++) push_word(W'(100 + i));
    drain();
    check("bp_pkt_count", pkt_count, base + 5);

    // Underrun inside a packet: no early termination.
    base = int'(pkt_count);
    pkt_len = 16'd6;
    for (int i = 0; i < 3; i++) push_word(W'(200 + i));
    repeat (10) tick();
    check("underrun_tvalid", tvalid, 0);
    check("underrun_state", dbg_state, ST_SEND);
    check("underrun_pkt_count", pkt_count, base);
    for (int i = 3; i < 6; i++) push_word(W'(200 + i));
    drain();
    check("underrun_done_pkt_count", pkt_count, base + 1);

    // Flush with 7 queued words.
    base = int'(pkt_count);
    pkt_len = 16'd4;
    tready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(W'(300 + i));
    check("preflush_level", fifo_level, 7);
    check("preflush_tvalid", tvalid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    model_beat = 0;
    check("flush_level", fifo_level, 0);
    check("flush_tvalid", tvalid, 0);
    check("flush_pkt_count", pkt_count, base);
    check("flush_wr_ptr", dbg_wr, 0);
    check("flush_rd_ptr", dbg_rd, 0);
    check("flush_state", dbg_state, ST_IDLE);
    tready = 1'b1;
    pkt_len = 16'd2;
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    drain();
    check("postflush_pkt_count", pkt_count, base + 1);

    // Asynchronous reset in the middle of a packet.
    pkt_len = 16'd4;
    tready = 1'b0;
    push_word(32'd400);
    push_word(32'd401);
    tready = 1'b1;
    tick();
    check("midpkt_tvalid", tvalid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", tvalid, 0);
    check("async_rst_tlast", tlast, 0);
    check("async_rst_tstrb", tstrb, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_pkt_count", pkt_count, 0);
    check("async_rst_core_ready", core_ready, 0);
    check("async_rst_wr_ptr", dbg_wr, 0);
    reset_and_startup();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
